// File: rtl/operand_b_stage_if.sv
// Decode->execute operand-B stage bus: upstream entry fields, bypass sources,
// downstream operand outputs and the valid/ready pair on each side.
interface operand_b_stage_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned FWD_PORTS = 2
);
    logic                      flush;
    logic                      in_valid;
    logic                      in_ready;
    logic [31:0]               instr;
    logic [2:0]                imm_sel;
    logic                      use_rs2;
    logic [4:0]                rs2_addr;
    logic [XLEN-1:0]           rs2_data;
    logic [FWD_PORTS-1:0]      fwd_valid;
    logic [5*FWD_PORTS-1:0]    fwd_addr;
    logic [XLEN*FWD_PORTS-1:0] fwd_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [XLEN-1:0]           out_opb;
    logic [XLEN-1:0]           out_imm;
    logic                      out_fwd;

    modport master (
        output flush, in_valid, instr, imm_sel, use_rs2, rs2_addr, rs2_data,
               fwd_valid, fwd_addr, fwd_data, out_ready,
        input  in_ready, out_valid, out_opb, out_imm, out_fwd
    );

    modport slave (
        input  flush, in_valid, instr, imm_sel, use_rs2, rs2_addr, rs2_data,
               fwd_valid, fwd_addr, fwd_data, out_ready,
        output in_ready, out_valid, out_opb, out_imm, out_fwd
    );
endinterface

// File: rtl/operand_b_stage.sv
// Registered operand-B stage: immediate decode, rs2 bypass select and a
// 2-entry skid buffer (output register + skid register) with valid/ready.
module operand_b_stage #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned FWD_PORTS = 2
) (
    input logic              clock,
    input logic              nReset,
    operand_b_stage_if.slave bus
);
    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] out_opb_q, out_imm_q, skid_opb_q, skid_imm_q;
    logic            out_fwd_q, skid_fwd_q;

    logic [31:0]     imm32;
    logic [XLEN-1:0] imm, fwd_sel, rs2_val, opb;
    logic            hit, take_fwd;
    logic            accept, drain, in_ready;
    logic            load_out_in, load_out_skid, load_skid;
    logic            unused_opcode;

    assign unused_opcode = ^bus.instr[6:0];

    // Every zero-extended format leaves imm32[31] clear, so one sign-extend covers all.
    always_comb begin
        imm32 = '0;
        case (bus.imm_sel)
            3'b000:  imm32 = {{20{bus.instr[31]}}, bus.instr[31:20]};
            3'b001:  imm32 = {20'b0, bus.instr[31:20]};
            3'b010:  imm32 = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
            3'b011:  imm32 = {bus.instr[31:12], 12'b0};
            3'b100:  imm32 = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                              bus.instr[30:25], bus.instr[11:8], 1'b0};
            3'b101:  imm32 = {{11{bus.instr[31]}}, bus.instr[31], bus.instr[19:12],
                              bus.instr[20], bus.instr[30:21], 1'b0};
            3'b110:  imm32 = (XLEN == 64) ? {26'b0, bus.instr[25:20]}
                                          : {27'b0, bus.instr[24:20]};
            default: imm32 = '0;
        endcase
        imm = XLEN'($signed(imm32));
    end

    always_comb begin
        hit     = 1'b0;
        fwd_sel = '0;
        for (int unsigned k = 0; k < FWD_PORTS; k++) begin
            if (!hit && bus.fwd_valid[k] && (bus.fwd_addr[k*5 +: 5] == bus.rs2_addr)) begin
                hit     = 1'b1;
                fwd_sel = bus.fwd_data[k*XLEN +: XLEN];
            end
        end
        if (bus.rs2_addr == 5'd0)
            rs2_val = '0;
        else if (hit)
            rs2_val = fwd_sel;
        else
            rs2_val = bus.rs2_data;
        opb      = bus.use_rs2 ? rs2_val : imm;
        take_fwd = bus.use_rs2 && hit && (bus.rs2_addr != 5'd0);
    end

    assign in_ready = (state_q != S_FULL);
    assign accept   = bus.in_valid && in_ready;
    assign drain    = (state_q != S_EMPTY) && bus.out_ready;

    always_comb begin
        state_d       = state_q;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (bus.flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: if (accept) begin
                    load_out_in = 1'b1;
                    state_d     = S_ONE;
                end
                S_ONE: begin
                    if (accept && drain) begin
                        load_out_in = 1'b1;
                    end else if (accept) begin
                        load_skid = 1'b1;
                        state_d   = S_FULL;
                    end else if (drain) begin
                        state_d = S_EMPTY;
                    end
                end
                S_FULL: if (drain) begin
                    load_out_skid = 1'b1;
                    state_d       = S_ONE;
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q    <= S_EMPTY;
            out_opb_q  <= '0;
            out_imm_q  <= '0;
            out_fwd_q  <= 1'b0;
            skid_opb_q <= '0;
            skid_imm_q <= '0;
            skid_fwd_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_out_in) begin
                out_opb_q <= opb;
                out_imm_q <= imm;
                out_fwd_q <= take_fwd;
            end else if (load_out_skid) begin
                out_opb_q <= skid_opb_q;
                out_imm_q <= skid_imm_q;
                out_fwd_q <= skid_fwd_q;
            end
            if (load_skid) begin
                skid_opb_q <= opb;
                skid_imm_q <= imm;
                skid_fwd_q <= take_fwd;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q != S_EMPTY);
    assign bus.out_opb   = out_opb_q;
    assign bus.out_imm   = out_imm_q;
    assign bus.out_fwd   = out_fwd_q;
endmodule
